pwm_deadtime: RTL and testbench

Three-phase gate-drive stage sitting directly downstream of the FOC controller's `pwmA_out`/`pwmB_out`/`pwmC_out`. It turns each single-ended PWM phase into a complementary high-side/low-side gate pair. A programmable dead interval separates every turn-off from the opposite turn-on. It also provides a latched fault shutdown and a clean re-arm sequence after enable or fault clear.

---
 rtl/pwm_deadtime.sv | 168 ++++++++++++++++
 tb/tb_pwm_deadtime.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Three-phase complementary gate driver with programmable dead time,
// latched fault shutdown and a full-dead-interval re-arm after any kill.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pwmA_in,
    input  logic                pwmB_in,
    input  logic                pwmC_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                enable,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic                gateAH_out,
    output logic                gateAL_out,
    output logic                gateBH_out,
    output logic                gateBL_out,
    output logic                gateCH_out,
    output logic                gateCL_out,
    output logic                fault_latched,
    output logic                armed
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_DEAD_H  = 3'd1,
        ST_HIGH_ON = 3'd2,
        ST_DEAD_L  = 3'd3,
        ST_LOW_ON  = 3'd4
    } state_t;

    localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

    logic [2:0]          pwm_raw;
    logic [2:0]          gate_h;
    logic [2:0]          gate_l;
    logic [2:0]          phase_on;
    logic [DT_WIDTH-1:0] dt_load;
    logic                kill;
    logic                fault_latched_reg;
    logic                fault_latched_next;
    logic                armed_reg;

    assign pwm_raw = {pwmC_in, pwmB_in, pwmA_in};

    // A programmed dead time of zero still guarantees one idle cycle.
    assign dt_load = (dead_time == '0) ? CNT_ONE : dead_time;

    // Uses the registered latch so a cleared fault still holds gates off for
    // the clearing edge; the raw fault input kills on the same edge.
    assign kill = !enable | fault_in | fault_latched_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_phase
            logic                pwm_q_reg;
            state_t              state_reg;
            state_t              state_next;
            logic [DT_WIDTH-1:0] cnt_reg;
            logic [DT_WIDTH-1:0] cnt_next;
            logic                gate_h_reg;
            logic                gate_l_reg;
            logic                gate_h_next;
            logic                gate_l_next;

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    pwm_q_reg  <= 1'b0;
                    state_reg  <= ST_OFF;
                    cnt_reg    <= '0;
                    gate_h_reg <= 1'b0;
                    gate_l_reg <= 1'b0;
                end else begin
                    pwm_q_reg  <= pwm_raw[gi];
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    gate_h_reg <= gate_h_next;
                    gate_l_reg <= gate_l_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (kill) begin
                    state_next = ST_OFF;
                end else begin
                    case (state_reg)
                        ST_OFF: begin
                            state_next = pwm_q_reg ? ST_DEAD_H : ST_DEAD_L;
                            cnt_next   = dt_load;
                        end
                        ST_LOW_ON: begin
                            if (pwm_q_reg) begin
                                state_next = ST_DEAD_H;
                                cnt_next   = dt_load;
                            end
                        end
                        ST_HIGH_ON: begin
                            if (!pwm_q_reg) begin
                                state_next = ST_DEAD_L;
                                cnt_next   = dt_load;
                            end
                        end
                        // Aborting a dead interval back to the side that was
                        // never released needs no extra dead time.
                        ST_DEAD_H: begin
                            if (!pwm_q_reg) begin
                                state_next = ST_LOW_ON;
                            end else if (cnt_reg == CNT_ONE) begin
                                state_next = ST_HIGH_ON;
                            end else begin
                                cnt_next = cnt_reg - CNT_ONE;
                            end
                        end
                        ST_DEAD_L: begin
                            if (pwm_q_reg) begin
                                state_next = ST_HIGH_ON;
                            end else if (cnt_reg == CNT_ONE) begin
                                state_next = ST_LOW_ON;
                            end else begin
                                cnt_next = cnt_reg - CNT_ONE;
                            end
                        end
                        default: begin
                            state_next = ST_OFF;
                        end
                    endcase
                end
                gate_h_next = (state_next == ST_HIGH_ON);
                gate_l_next = (state_next == ST_LOW_ON);
            end

            assign gate_h[gi]   = gate_h_reg;
            assign gate_l[gi]   = gate_l_reg;
            assign phase_on[gi] = (state_reg == ST_HIGH_ON) || (state_reg == ST_LOW_ON);
        end
    endgenerate

    always_comb begin
        fault_latched_next = fault_latched_reg;
        if (fault_in) begin
            fault_latched_next = 1'b1;
        end else if (fault_clr) begin
            fault_latched_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fault_latched_reg <= 1'b0;
            armed_reg         <= 1'b0;
        end else begin
            fault_latched_reg <= fault_latched_next;
            armed_reg         <= &phase_on;
        end
    end

    assign gateAH_out    = gate_h[0];
    assign gateAL_out    = gate_l[0];
    assign gateBH_out    = gate_h[1];
    assign gateBL_out    = gate_l[1];
    assign gateCH_out    = gate_h[2];
    assign gateCL_out    = gate_l[2];
    assign fault_latched = fault_latched_reg;
    assign armed         = armed_reg;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and randomised checks of pwm_deadtime against a cycle-level
// behavioural model of the dead-time rules.
`timescale 1ns/1ps
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       pwmA_in = 1'b0, pwmB_in = 1'b0, pwmC_in = 1'b0;
    logic [7:0] dead_time = 8'd4;
    logic       enable = 1'b1, fault_in = 1'b0, fault_clr = 1'b0;
    logic       gateAH_out, gateAL_out, gateBH_out, gateBL_out, gateCH_out, gateCL_out;
    logic       fault_latched, armed;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk(clk), .rstb(rstb),
        .pwmA_in(pwmA_in), .pwmB_in(pwmB_in), .pwmC_in(pwmC_in),
        .dead_time(dead_time), .enable(enable),
        .fault_in(fault_in), .fault_clr(fault_clr),
        .gateAH_out(gateAH_out), .gateAL_out(gateAL_out),
        .gateBH_out(gateBH_out), .gateBL_out(gateBL_out),
        .gateCH_out(gateCH_out), .gateCL_out(gateCL_out),
        .fault_latched(fault_latched), .armed(armed)
    );

    logic [2:0] pwm_vec;
    logic [5:0] gates;
    assign pwm_vec = {pwmC_in, pwmB_in, pwmA_in};
    assign gates   = {gateCH_out, gateCL_out, gateBH_out, gateBL_out, gateAH_out, gateAL_out};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each phase has a target side and a remaining wait; the target
    // gate is on once the wait has run out. A killed phase has no target.
    initial begin : model
        int         rem [3];
        bit         tgt [3];
        bit         vld [3];
        bit         qm  [3];
        bit         fm, allon, earm, kl, on_all;
        int         dv;
        logic [7:0] exp_v;
        for (int p = 0; p < 3; p++) begin
            rem[p] = 0; tgt[p] = 0; vld[p] = 0; qm[p] = 0;
        end
        fm = 0; allon = 0; earm = 0;
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) begin
                for (int p = 0; p < 3; p++) begin
                    rem[p] = 0; tgt[p] = 0; vld[p] = 0; qm[p] = 0;
                end
                fm = 0; allon = 0; earm = 0;
            end else begin
                kl = !enable || fault_in || fm;
                dv = (dead_time == 8'd0) ? 1 : int'(dead_time);
                on_all = 1;
                for (int p = 0; p < 3; p++) begin
                    if (kl) begin
                        vld[p] = 0; rem[p] = 0;
                    end else if (!vld[p]) begin
                        vld[p] = 1; tgt[p] = qm[p]; rem[p] = dv;
                    end else if (qm[p] != tgt[p]) begin
                        rem[p] = (rem[p] > 0) ? 0 : dv;
                        tgt[p] = qm[p];
                    end else if (rem[p] > 0) begin
                        rem[p] = rem[p] - 1;
                    end
                    if (!(vld[p] && rem[p] == 0)) on_all = 0;
                end
                earm  = allon;
                allon = on_all;
                if (fault_in) fm = 1;
                else if (fault_clr) fm = 0;
                for (int p = 0; p < 3; p++) qm[p] = pwm_vec[p];
            end
            exp_v = '0;
            for (int p = 0; p < 3; p++) begin
                exp_v[2*p+3] = vld[p] && rem[p] == 0 && tgt[p];
                exp_v[2*p+2] = vld[p] && rem[p] == 0 && !tgt[p];
            end
            exp_v[1] = fm;
            exp_v[0] = earm;
            #1;
            check("model_outputs", 32'({gates, fault_latched, armed}), 32'(exp_v));
            check("no_shoot_through",
                  32'((gateAH_out & gateAL_out) | (gateBH_out & gateBL_out) | (gateCH_out & gateCL_out)), 0);
        end
    end

    initial begin : driver
        int  cnt;
        bit  rose;
        bit  bh_seen;
        // Reset, then re-arm to LOW_ON with a 4-cycle dead interval.
        tick(3);
        check("rst_gates", 32'(gates), 0);
        check("rst_flags", 32'({fault_latched, armed}), 0);
        rstb = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("rearm_AL_low", 32'(gateAL_out), 0);
        end
        tick(1);
        check("rearm_AL_rise", 32'(gateAL_out), 1);
        check("armed_lag", 32'(armed), 0);
        tick(1);
        check("armed_set", 32'(armed), 1);

        // Nominal rising and falling edges, dead_time = 3.
        dead_time = 8'd3;
        pwmA_in = 1'b1;
        tick(1); check("nom_AL_still_on", 32'(gateAL_out), 1);
        tick(1); check("nom_A_gap", 32'({gateAH_out, gateAL_out}), 0);
        tick(2); check("nom_AH_not_yet", 32'(gateAH_out), 0);
        tick(1); check("nom_AH_rise", 32'(gateAH_out), 1);
        pwmA_in = 1'b0;
        tick(1); check("nom_AH_still_on", 32'(gateAH_out), 1);
        tick(1); check("nom_A_gap2", 32'({gateAH_out, gateAL_out}), 0);
        tick(2); check("nom_AL_not_yet", 32'(gateAL_out), 0);
        tick(1); check("nom_AL_rise", 32'(gateAL_out), 1);

        // Zero dead time behaves as one cycle.
        dead_time = 8'd0;
        pwmA_in = 1'b1;
        tick(1);
        tick(1); check("dt0_gap", 32'({gateAH_out, gateAL_out}), 0);
        tick(1); check("dt0_AH_rise", 32'(gateAH_out), 1);

        // Maximum dead time, with a mid-interval change that must be ignored.
        dead_time = 8'd255;
        pwmA_in = 1'b0;
        tick(1);
        cnt = 0; rose = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 10) dead_time = 8'd1;
            tick(1);
            if (gateAL_out) begin
                rose = 1;
                break;
            end
            if (!gateAH_out && !gateAL_out) cnt++;
        end
        check("dt255_AL_rose", 32'(rose), 1);
        check("dt255_gap_len", 32'(cnt), 255);

        // Pulse shorter than the dead time on phase B.
        dead_time = 8'd5;
        pwmB_in = 1'b1;
        cnt = 0; bh_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) pwmB_in = 1'b0;
            tick(1);
            if (gateBH_out) bh_seen = 1;
            if (!gateBL_out) cnt++;
        end
        check("short_BH_never", 32'(bh_seen), 0);
        check("short_BL_low_len", 32'(cnt), 2);

        // Fault handling from all phases HIGH_ON.
        dead_time = 8'd3;
        pwmA_in = 1'b1; pwmB_in = 1'b1; pwmC_in = 1'b1;
        tick(8);
        check("all_high_on", 32'(gates), 32'h2A);
        fault_in = 1'b1;
        tick(1);
        check("fault_gates_off", 32'(gates), 0);
        check("fault_latched_set", 32'(fault_latched), 1);
        fault_in = 1'b0;
        tick(3);
        check("fault_sticky", 32'({fault_latched, gates}), 32'h40);
        fault_in = 1'b1; fault_clr = 1'b1;
        tick(1);
        check("fault_set_wins", 32'(fault_latched), 1);
        fault_in = 1'b0;
        tick(1);
        check("fault_cleared", 32'(fault_latched), 0);
        check("clr_edge_gates_off", 32'(gates), 0);
        fault_clr = 1'b0;
        tick(3);
        check("clr_rearm_wait", 32'(gateAH_out), 0);
        tick(1);
        check("clr_rearm_AH", 32'(gateAH_out), 1);

        // Enable low kills on the same edge.
        enable = 1'b0;
        tick(1);
        check("disable_gates_off", 32'(gates), 0);
        enable = 1'b1;
        tick(6);

        // Randomised traffic; the model process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) pwmA_in = ~pwmA_in;
            if ($urandom_range(0, 5) == 0) pwmB_in = ~pwmB_in;
            if ($urandom_range(0, 5) == 0) pwmC_in = ~pwmC_in;
            if ($urandom_range(0, 19) == 0) dead_time = 8'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 39) != 0);
            fault_in  = ($urandom_range(0, 99) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
            tick(1);
        end
        fault_in = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
